// File: rtl/lc3_mem_pkg.sv
// Shared types and defaults for the LC-3 memory responder.
package lc3_mem_pkg;

  typedef logic [15:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE,
    RELEASE
  } mem_state_t;

  localparam int    DEFAULT_WAIT_STATES = 2;
  localparam word_t DEFAULT_IO_ADDR     = 16'hFFFF;

endpackage

// File: rtl/lc3_mem_if.sv
// Datapath <-> memory bus: request side (MAR/MDR/OE/WE) and response side (MDR_In/R/Busy).
interface lc3_mem_if;
  import lc3_mem_pkg::*;

  word_t MAR;
  word_t MDR;
  logic  MEM_OE;
  logic  MEM_WE;
  word_t MDR_In;
  logic  R;
  logic  Busy;

  modport master (
    output MAR, MDR, MEM_OE, MEM_WE,
    input  MDR_In, R, Busy
  );

  modport slave (
    input  MAR, MDR, MEM_OE, MEM_WE,
    output MDR_In, R, Busy
  );

endinterface

// File: rtl/lc3_mem_sram_sp.sv
// Single-port synchronous RAM with registered read, written to map onto block RAM.
module sram_sp
  import lc3_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              Clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  word_t             din,
  output word_t             dout
);

  word_t mem [2**ADDR_W];
  word_t dout_q;

  // Write port and read-first registered read port on the same address.
  // NOTE: the array and its output register carry no reset so the tools can place them in block RAM.
  always_ff @(posedge Clk) begin
    if (we) begin
      mem[addr] <= din;
    end
    dout_q <= mem[addr];
  end

  assign dout = dout_q;

endmodule

// File: rtl/lc3_mem_responder.sv
// Memory-side responder: FSM, wait counter, request latches, I/O decode and LED register.
module lc3_mem_responder
  import lc3_mem_pkg::*;
#(
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_STATES = DEFAULT_WAIT_STATES,
  parameter word_t IO_ADDR     = DEFAULT_IO_ADDR
) (
  input  logic        Clk,
  input  logic        Reset,
  lc3_mem_if.slave    bus,
  input  word_t       SW,
  output word_t       LED
);

  localparam int CNT_W = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

  mem_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  word_t            addr_q, addr_d;
  word_t            data_q, data_d;
  logic             wr_q, wr_d;
  word_t            mdr_in_q, mdr_in_d;
  word_t            led_q, led_d;

  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  word_t             ram_dout;
  logic              is_io;

  assign is_io = (addr_q == IO_ADDR);

  // In IDLE the RAM sees the live MAR so a zero-wait read has data ready in ACCESS.
  assign ram_addr = (state_q == IDLE) ? bus.MAR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];

  sram_sp #(.ADDR_W(ADDR_W)) u_ram (
    .Clk  (Clk),
    .we   (ram_we && !Reset),
    .addr (ram_addr),
    .din  (data_q),
    .dout (ram_dout)
  );

  // Next-state, request latching and access-cycle side effects.
  // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    mdr_in_d = mdr_in_q;
    led_d    = led_q;
    ram_we   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.MEM_OE || bus.MEM_WE) begin
          addr_d = bus.MAR;
          data_d = bus.MDR;
          wr_d   = bus.MEM_WE;
          if (WAIT_STATES == 0) begin
            state_d = ACCESS;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(WAIT_STATES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        state_d = DONE;
        if (wr_q) begin
          if (is_io) begin
            led_d = data_q;
          end else begin
            ram_we = 1'b1;
          end
        end else begin
          mdr_in_d = is_io ? SW : ram_dout;
        end
      end
      DONE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!bus.MEM_OE && !bus.MEM_WE) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset also cancels a pending access.
  // NOTE: non-blocking assignments so every flop samples the pre-edge values together.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      wr_q     <= 1'b0;
      mdr_in_q <= '0;
      led_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      wr_q     <= wr_d;
      mdr_in_q <= mdr_in_d;
      led_q    <= led_d;
    end
  end

  assign bus.MDR_In = mdr_in_q;
  assign bus.R      = (state_q == DONE);
  assign bus.Busy   = (state_q != IDLE);
  assign LED        = led_q;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: dut0 uses two wait states, dut1 uses zero wait states.
module tb_lc3_mem_responder;
  import lc3_mem_pkg::*;

  logic  clk = 1'b0;
  logic  rst0, rst1;
  word_t sw;
  word_t led0, led1;

  lc3_mem_if b0 ();
  lc3_mem_if b1 ();

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(2), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(clk), .Reset(rst0), .bus(b0), .SW(sw), .LED(led0)
  );

  lc3_mem_responder #(.ADDR_W(10), .WAIT_STATES(0), .IO_ADDR(16'hFFFF)) dut1 (
    .Clk(clk), .Reset(rst1), .bus(b1), .SW(sw), .LED(led1)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  word_t sb[$];
  word_t last_rd[2];

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic r_of(int s);
    return (s != 0) ? b1.R : b0.R;
  endfunction

  function automatic logic busy_of(int s);
    return (s != 0) ? b1.Busy : b0.Busy;
  endfunction

  function automatic word_t mdr_of(int s);
    return (s != 0) ? b1.MDR_In : b0.MDR_In;
  endfunction

  function automatic int ws_of(int s);
    return (s != 0) ? 0 : 2;
  endfunction

  task automatic drive(int s, logic oe, logic we, word_t mar, word_t mdr);
    if (s != 0) begin
      b1.MEM_OE = oe; b1.MEM_WE = we; b1.MAR = mar; b1.MDR = mdr;
    end else begin
      b0.MEM_OE = oe; b0.MEM_WE = we; b0.MAR = mar; b0.MDR = mdr;
    end
  endtask

  // One full transaction: request, latency + data check via scoreboard, one-cycle R, release.
  task automatic access(int s, string tag, logic is_wr, word_t mar, word_t mdr, word_t exp_rd);
    bit seen = 0;
    @(negedge clk);
    drive(s, !is_wr, is_wr, mar, mdr);
    sb.push_back(is_wr ? last_rd[s] : exp_rd);
    if (!is_wr) last_rd[s] = exp_rd;
    for (int k = 1; k <= 40 && !seen; k++) begin
      @(negedge clk);
      if (r_of(s)) begin
        seen = 1;
        check({tag, " latency"}, k, ws_of(s) + 2);
        check({tag, " data"}, mdr_of(s), sb.pop_front());
      end
    end
    if (!seen) begin
      check({tag, " timeout"}, 32'd0, 32'd1);
      void'(sb.pop_front());
    end
    @(negedge clk);
    check({tag, " R one cycle"}, r_of(s), 1'b0);
    drive(s, 1'b0, 1'b0, mar, mdr);
    @(negedge clk);
    check({tag, " idle after release"}, busy_of(s), 1'b0);
  endtask

  // Hold OE for ten cycles and count R pulses.
  task automatic held_read(string tag, word_t mar, word_t exp_rd);
    int pulses = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0, mar, 16'h0000);
    sb.push_back(exp_rd);
    last_rd[0] = exp_rd;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (b0.R) begin
        pulses++;
        if (sb.size() != 0) check({tag, " data"}, b0.MDR_In, sb.pop_front());
      end
    end
    check({tag, " pulses"}, pulses, 1);
    check({tag, " busy while held"}, b0.Busy, 1'b1);
    while (sb.size() != 0) void'(sb.pop_front());
    drive(0, 1'b0, 1'b0, mar, 16'h0000);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; sw = 16'h1234;
    drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    last_rd[0] = 16'h0000; last_rd[1] = 16'h0000;
    repeat (3) @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0;

    // Reset state
    check("rst R0", b0.R, 1'b0);
    check("rst busy0", b0.Busy, 1'b0);
    check("rst led0", led0, 16'h0000);
    check("rst mdr0", b0.MDR_In, 16'h0000);
    check("rst R1", b1.R, 1'b0);
    check("rst busy1", b1.Busy, 1'b0);

    // Write / read back
    access(0, "wr 0010", 1'b1, 16'h0010, 16'hBEEF, 16'h0000);
    access(0, "rd 0010", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // I/O reads follow SW, RAM untouched
    sw = 16'h1234;
    access(0, "io rd a", 1'b0, 16'hFFFF, 16'h0000, 16'h1234);
    sw = 16'h5678;
    access(0, "io rd b", 1'b0, 16'hFFFF, 16'h0000, 16'h5678);
    access(0, "rd 0010 again", 1'b0, 16'h0010, 16'h0000, 16'hBEEF);

    // I/O write loads LED, aliased RAM word 0x3FF unchanged
    access(0, "wr 03FF", 1'b1, 16'h03FF, 16'h1357, 16'h0000);
    check("led before io wr", led0, 16'h0000);
    access(0, "io wr", 1'b1, 16'hFFFF, 16'h00A5, 16'h0000);
    check("led after io wr", led0, 16'h00A5);
    access(0, "rd 03FF", 1'b0, 16'h03FF, 16'h0000, 16'h1357);

    // Held request: one pulse per assertion
    held_read("held a", 16'h0010, 16'hBEEF);
    held_read("held b", 16'h0010, 16'hBEEF);

    // Zero wait states and address aliasing
    access(1, "z wr 0405", 1'b1, 16'h0405, 16'h7777, 16'h0000);
    access(1, "z rd 0005", 1'b0, 16'h0005, 16'h0000, 16'h7777);

    // Reset during WAIT discards the write
    access(0, "wr 0020", 1'b1, 16'h0020, 16'h0001, 16'h0000);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0020, 16'hFFFF);
    @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0020, 16'hFFFF);
    check("R low in reset cycle", b0.R, 1'b0);
    @(negedge clk);
    check("post rst R", b0.R, 1'b0);
    check("post rst busy", b0.Busy, 1'b0);
    check("post rst led", led0, 16'h0000);
    check("post rst mdr", b0.MDR_In, 16'h0000);
    last_rd[0] = 16'h0000;
    rst0 = 1'b0;
    access(0, "rd 0020", 1'b0, 16'h0020, 16'h0000, 16'h0001);

    // Reset on the ACCESS edge also discards the write
    access(0, "wr 0030", 1'b1, 16'h0030, 16'h1111, 16'h0000);
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 16'h0030, 16'h2222);
    repeat (3) @(negedge clk);
    rst0 = 1'b1;
    drive(0, 1'b0, 1'b0, 16'h0030, 16'h2222);
    @(negedge clk);
    check("acc rst R", b0.R, 1'b0);
    check("acc rst busy", b0.Busy, 1'b0);
    last_rd[0] = 16'h0000;
    rst0 = 1'b0;
    access(0, "rd 0030", 1'b0, 16'h0030, 16'h0000, 16'h1111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
